// File: rtl/weight_stream.sv
// Writable NCH x DEPTH weight store that streams one channel to a MAC over valid/ready.
// Define WEIGHT_WR_EN to enable the runtime write port; otherwise the weights are constant defaults.
module weight_stream #(
  parameter int unsigned W_WIDTH = 8,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned NCH     = 2,
  parameter int unsigned CH_W    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [CH_W-1:0]    wr_ch,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [W_WIDTH-1:0] wr_data,
  input  logic               start,
  input  logic [CH_W-1:0]    start_ch,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W_WIDTH-1:0] out_weight,
  output logic [ADDR_W-1:0]  out_index,
  output logic               out_last,
  output logic               done
);

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  state_e             state_q, state_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [W_WIDTH-1:0] word_q, word_d;
  logic               done_q, done_d;

  logic [CH_W-1:0]    rd_ch;
  logic [ADDR_W-1:0]  rd_addr;
  logic [W_WIDTH-1:0] rd_word;

  // Built-in classifier weights: channel 0, entries 0..15; everything else zero.
  function automatic logic [W_WIDTH-1:0] dflt(input int unsigned c, input int unsigned a);
    int unsigned v;
    v = 0;
    if (c == 0) begin
      case (a)
        0:  v = 177;
        1:  v = 215;
        2:  v = 233;
        3:  v = 138;
        4:  v = 183;
        5:  v = 221;
        6:  v = 238;
        7:  v = 137;
        8:  v = 184;
        9:  v = 221;
        10: v = 238;
        11: v = 138;
        12: v = 184;
        13: v = 221;
        14: v = 210;
        15: v = 99;
        default: v = 0;
      endcase
    end
    return W_WIDTH'(v);
  endfunction

`ifdef WEIGHT_WR_EN
  logic [W_WIDTH-1:0] mem_q [NCH][DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        for (int unsigned a = 0; a < DEPTH; a++) begin
          mem_q[c][a] <= dflt(c, a);
        end
      end
    end else if (wr_en && (32'(wr_ch) < NCH)) begin
      mem_q[wr_ch][wr_addr] <= wr_data;
    end
  end

  // Read sees pre-edge contents, so a same-cycle write to the loaded entry is not streamed.
  assign rd_word = (32'(rd_ch) < NCH) ? mem_q[rd_ch][rd_addr] : '0;
`else
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_ch, wr_addr, wr_data};

  assign rd_word = (32'(rd_ch) < NCH) ? dflt(32'(rd_ch), 32'(rd_addr)) : '0;
`endif

  always_comb begin
    rd_ch   = ch_q;
    rd_addr = idx_q + 1'b1;
    if (state_q == StIdle) begin
      rd_ch   = start_ch;
      rd_addr = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    idx_d   = idx_q;
    word_d  = word_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          ch_d    = start_ch;
          idx_d   = '0;
          word_d  = rd_word;
          state_d = StStream;
        end
      end
      StStream: begin
        if (out_ready) begin
          if (out_last) begin
            idx_d   = '0;
            word_d  = '0;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            idx_d  = idx_q + 1'b1;
            word_d = rd_word;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ch_q    <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      done_q  <= done_d;
    end
  end

  assign busy       = (state_q == StStream);
  assign out_valid  = busy;
  assign out_weight = word_q;
  assign out_index  = idx_q;
  assign out_last   = (idx_q == ADDR_W'(DEPTH - 1));
  assign done       = done_q;

endmodule

// File: tb/tb_weight_stream.sv
// Directed bench for weight_stream: streaming, backpressure, writes, collision,
// start-while-busy and mid-stream reset.
module tb_weight_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic       wr_ch;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       start;
  logic       start_ch;
  logic       busy;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_weight;
  logic [3:0] out_index;
  logic       out_last;
  logic       done;

  int checks   = 0;
  int failures = 0;

  int unsigned exp0 [16] = '{177, 215, 233, 138, 183, 221, 238, 137,
                             184, 221, 238, 138, 184, 221, 210, 99};
  int unsigned exp_cur [16];

`ifdef WEIGHT_WR_EN
  localparam bit WrEn = 1'b1;
`else
  localparam bit WrEn = 1'b0;
`endif

  always #5 clk = ~clk;

  weight_stream #(
    .W_WIDTH(8),
    .DEPTH  (16),
    .ADDR_W (4),
    .NCH    (2),
    .CH_W   (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_ch     (wr_ch),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
    .start_ch  (start_ch),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_weight(out_weight),
    .out_index (out_index),
    .out_last  (out_last),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Full-rate stream of one channel against exp_cur; optionally write 0x11 to
  // entry wr_at+1 in the cycle that entry is loaded (wr_at < 0 disables).
  task automatic stream_check(input logic chsel, input string tag, input int wr_at);
    start = 1'b1; start_ch = chsel; out_ready = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk({tag, "_valid"}, 32'(out_valid), 1);
      chk({tag, "_busy"}, 32'(busy), 1);
      chk({tag, "_index"}, 32'(out_index), 32'(i));
      chk({tag, "_weight"}, 32'(out_weight), exp_cur[i]);
      chk({tag, "_last"}, 32'(out_last), (i == 15) ? 1 : 0);
      chk({tag, "_nodone"}, 32'(done), 0);
      if (i == wr_at) begin
        wr_en = 1'b1; wr_ch = chsel; wr_addr = 4'(i + 1); wr_data = 8'h11;
      end
      cyc();
      wr_en = 1'b0;
    end
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_done_busy"}, 32'(busy), 0);
    chk({tag, "_done_valid"}, 32'(out_valid), 0);
    chk({tag, "_done_index"}, 32'(out_index), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dones;
    rst_n = 1'b0; wr_en = 1'b0; wr_ch = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; start_ch = 1'b0; out_ready = 1'b0;
    #2;
    chk("rst_async_valid", 32'(out_valid), 0);
    chk("rst_async_busy", 32'(busy), 0);
    cyc(); cyc();
    @(negedge clk) rst_n = 1'b1;
    cyc();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_index", 32'(out_index), 0);
    chk("rst_weight", 32'(out_weight), 0);
    chk("rst_last", 32'(out_last), 0);

    // Full-rate default stream
    exp_cur = exp0;
    stream_check(1'b0, "full", -1);
    cyc();
    chk("full_done_pulse", 32'(done), 0);

    // Backpressure at index 2
    start = 1'b1; start_ch = 1'b0; out_ready = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc();
    chk("bp_idx2", 32'(out_index), 2);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("bp_hold_valid", 32'(out_valid), 1);
      chk("bp_hold_index", 32'(out_index), 2);
      chk("bp_hold_weight", 32'(out_weight), 233);
    end
    out_ready = 1'b1;
    cyc();
    chk("bp_resume_index", 32'(out_index), 3);
    chk("bp_resume_weight", 32'(out_weight), 138);
    for (int k = 3; k < 16; k++) cyc();
    chk("bp_done", 32'(done), 1);
    cyc();

    // Write channel 1 entry 5, then stream channel 1
    wr_en = 1'b1; wr_ch = 1'b1; wr_addr = 4'd5; wr_data = 8'h5A;
    cyc();
    wr_en = 1'b0;
    for (int i = 0; i < 16; i++) exp_cur[i] = (WrEn && i == 5) ? 32'h5A : 0;
    stream_check(1'b1, "wr1", -1);
    cyc();

    // Collision: write entry 7 in the cycle it is loaded; old value streams
    exp_cur = exp0;
    stream_check(1'b0, "coll", 6);
    cyc();
    if (WrEn) exp_cur[7] = 32'h11;
    stream_check(1'b0, "coll2", -1);
    cyc();

    // Start while busy is ignored; start in the done cycle is accepted
    start = 1'b1; start_ch = 1'b0; out_ready = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 4; k++) cyc();
    chk("swb_idx4", 32'(out_index), 4);
    start = 1'b1; start_ch = 1'b1;
    cyc();
    start = 1'b0;
    dones = 0;
    for (int k = 5; k < 16; k++) begin
      chk("swb_index", 32'(out_index), 32'(k));
      chk("swb_weight", 32'(out_weight), exp_cur[k]);
      if (done) dones++;
      cyc();
    end
    if (done) dones++;
    chk("swb_done_now", 32'(done), 1);
    chk("swb_one_done", 32'(dones), 1);
    start = 1'b1; start_ch = 1'b0;
    cyc();
    start = 1'b0;
    chk("swb_restart_valid", 32'(out_valid), 1);
    chk("swb_restart_index", 32'(out_index), 0);
    chk("swb_restart_weight", 32'(out_weight), exp_cur[0]);
    chk("swb_restart_nodone", 32'(done), 0);

    // Reset at index 9
    for (int k = 0; k < 9; k++) cyc();
    chk("mid_idx9", 32'(out_index), 9);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_index", 32'(out_index), 0);
    @(negedge clk) rst_n = 1'b1;
    cyc();
    chk("post_rst_done", 32'(done), 0);
    chk("post_rst_busy", 32'(busy), 0);
    exp_cur = exp0;
    stream_check(1'b0, "post_rst", -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/weight_stream.md
Name: weight_stream

Overview:
- Parametrised, writable weight store for the SPI-ADC classifier datapath. Holds NCH channels of DEPTH weights, each W_WIDTH bits wide.
- Streams one channel, entry by entry, to a downstream MAC over a valid/ready handshake.
- Reset loads the built-in default weights. Runtime updates arrive from the SPI register interface through a write port.

Parameters:
- W_WIDTH, 8, weight width in bits.
- DEPTH, 16, entries per channel (power of two, ≥2).
- ADDR_W, 4, address width; must equal log2(DEPTH).
- NCH, 2, number of weight channels (power of two, ≥1).
- CH_W, 1, channel select width; max(1, log2(NCH)).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  weight write strobe.
- wr_ch  in  CH_W  write channel.
- wr_addr  in  ADDR_W  write entry.
- wr_data  in  W_WIDTH  write value.
- start  in  1  request to stream a channel.
- start_ch  in  CH_W  channel to stream, sampled with start.
- busy  out  1  stream in progress.
- out_valid  out  1  out_weight holds a valid word.
- out_ready  in  1  consumer accepts the word.
- out_weight  out  W_WIDTH  streamed weight.
- out_index  out  ADDR_W  entry index of out_weight.
- out_last  out  1  current word is entry DEPTH-1.
- done  out  1  one-cycle pulse when a stream completes.

Behaviour:
- Reset (async assert, sync release): all outputs are 0 and the FSM is in IDLE.
- Reset memory contents:
  - Channel 0 entries 0..15 = 177,215,233,138,183,221,238,137,184,221,238,138,184,221,210,99, truncated to W_WIDTH.
  - Entries ≥16 and all other channels = 0.
- Write port: when wr_en=1, mem[wr_ch][wr_addr] ← wr_data at the clock edge. Writes are accepted in any state. Out-of-range wr_ch (NCH not a power of two) is ignored.
- FSM has two states, IDLE and STREAM.
- IDLE:
  - start=1 latches start_ch and moves to STREAM.
  - Next cycle: busy=1, out_valid=1, out_index=0, out_weight=mem[ch][0].
  - Latency from start to first word is 1 cycle.
- STREAM, handshake rules:
  - A word transfers when out_valid & out_ready.
  - Without a transfer, out_weight, out_index and out_last hold stable; out_valid never drops without a transfer.
  - A transfer on index i<DEPTH-1 presents index i+1 on the next cycle, with no bubble. Full rate is one word per cycle with out_ready held high.
  - out_last = (out_index == DEPTH-1).
- Completion: a transfer with out_last=1 returns the FSM to IDLE. On the next cycle out_valid=0, busy=0, done=1 for exactly one cycle, and out_index=0.
- start handling:
  - start while busy=1 is ignored, with no queuing.
  - start is accepted in the done cycle.
- Read/write collision: each output word is registered from memory at the cycle it is loaded. A write to the same channel and entry in that same cycle is not seen; the old value is streamed. Writes to entries not yet loaded are seen.
- Reset asserted mid-stream: immediate return to IDLE, outputs cleared, memory reloaded to defaults, no done pulse.

Optional Feature:
- Macro: WEIGHT_WR_EN.
- Defined: write port is functional as above.
- Undefined:
  - Storage is constant, holding the default contents only.
  - wr_en, wr_ch, wr_addr and wr_data are ignored and may be left unconnected.
  - Implement as a combinational lookup feeding the output register. Streaming timing is unchanged.

Test Plan:
- Stream, full rate: release reset, start=1 with start_ch=0, out_ready=1 held.
  - Required: 16 consecutive valid cycles with out_weight 177,215,…,210,99 and out_index 0..15.
  - Required: out_last only at index 15; done high on the following cycle; busy low in that cycle.
- Backpressure: stream channel 0 and drop out_ready for 3 cycles while index 2 (233) is presented.
  - Required: out_weight=233, out_index=2, out_valid=1 held for all 3 cycles.
  - Required: index 3 (138) is presented one cycle after out_ready returns high.
- Write then read (WEIGHT_WR_EN defined): write channel 1 entry 5 = 0x5A, then stream channel 1.
  - Required: index 5 = 0x5A; all other indices = 0.
- Collision: stream channel 0 with out_ready=1, and write 0x11 to entry 7 in the cycle entry 7 is loaded.
  - Required: 137 is streamed.
  - Required: a second stream yields 0x11 at index 7.
- Start while busy: pulse start with start_ch=1 at index 4 of a channel-0 stream.
  - Required: the stream continues on channel 0 unaffected and exactly one done pulse occurs.
  - Required: start in the done cycle begins a new stream next cycle.
- Reset mid-stream: assert rst_n=0 at index 9.
  - Required: out_valid, busy and done are all 0 asynchronously, with no done pulse.
  - Required: after release, a channel-0 stream returns the defaults, including any entry previously overwritten.
